// File: rtl/pool_scheduler.sv
// Round-robin scheduler sharing one mean-pooling unit between N window requesters.
// Sequences the unit's load/run/done handshake and returns tagged results on a valid/ready port.
module pool_scheduler #(
    parameter int IL   = 8,
    parameter int FL   = 12,
    parameter int size = 4,
    parameter int N    = 4,
    parameter int IDW  = $clog2(N),
    localparam int W   = IL + FL
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N-1:0]                     req,
    input  logic [N-1:0][size-1:0][W-1:0]    win,
    output logic [N-1:0]                     ack,
    output logic                             pool_en,
    output logic                             pool_load,
    output logic [size-1:0][W-1:0]           pool_im,
    input  logic [W-1:0]                     pool_om,
    input  logic                             pool_done,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [W-1:0]                     out_data,
    output logic [IDW-1:0]                   out_id,
    output logic                             err,
    output logic [IDW-1:0]                   err_id
);

    localparam int WDW = $clog2(size + 3) + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t            state;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    gnt_id;
    logic [WDW-1:0]    wd;
    logic [IDW-1:0]    gnt_next;
    logic [N-1:0]      gnt_onehot;

    // First requesting index at or after p, searching upward with wrap.
    function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
        logic [IDW-1:0] pick;
        int             idx;
        pick = p;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % N;
            if (r[idx]) begin
                pick = IDW'(idx);
            end
        end
        return pick;
    endfunction

    function automatic logic [IDW-1:0] inc_id(input logic [IDW-1:0] id);
        if (int'(id) == N - 1) begin
            return '0;
        end else begin
            return id + IDW'(1);
        end
    endfunction

    // Grant candidate and one-hot of the current grant.
    always_comb begin
        gnt_next   = rr_pick(req, rr_ptr);
        gnt_onehot = {{(N-1){1'b0}}, 1'b1} << gnt_id;
    end

    assign pool_im = win[gnt_id];

    // Scheduler FSM with all handshake outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt_id    <= '0;
            wd        <= '0;
            ack       <= '0;
            pool_en   <= 1'b0;
            pool_load <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            err       <= 1'b0;
            err_id    <= '0;
        end else begin
            ack <= '0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt_id    <= gnt_next;
                        pool_en   <= 1'b1;
                        pool_load <= 1'b1;
                        state     <= LOAD;
                    end else begin
                        pool_en   <= 1'b0;
                        pool_load <= 1'b0;
                    end
                end
                LOAD: begin
                    wd        <= '0;
                    pool_en   <= 1'b1;
                    pool_load <= 1'b0;
                    state     <= RUN;
                end
                RUN: begin
                    // done has priority over a watchdog expiry in the same cycle
                    if (pool_done) begin
                        pool_en <= 1'b0;
                        ack     <= gnt_onehot;
                        rr_ptr  <= inc_id(gnt_id);
                        state   <= CAPTURE;
                    end else if (wd == WDW'(size + 2)) begin
                        pool_en <= 1'b0;
                        err     <= 1'b1;
                        err_id  <= gnt_id;
                        ack     <= gnt_onehot;
                        rr_ptr  <= inc_id(gnt_id);
                        state   <= IDLE;
                    end else begin
                        wd <= wd + WDW'(1);
                    end
                end
                CAPTURE: begin
                    out_data  <= pool_om;
                    out_id    <= gnt_id;
                    out_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    pool_en   <= 1'b0;
                    pool_load <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pool_scheduler.sv
// Directed bench for pool_scheduler with a behavioural mean-pooling unit model.
module tb_pool_scheduler;

    localparam int N    = 4;
    localparam int SIZE = 4;
    localparam int W    = 20;
    localparam int IDW  = 2;

    logic                            clk = 1'b0;
    logic                            rst_n = 1'b0;
    logic [N-1:0]                    req = '0;
    logic [N-1:0][SIZE-1:0][W-1:0]   win = '0;
    logic [N-1:0]                    ack;
    logic                            pool_en, pool_load, pool_done;
    logic [SIZE-1:0][W-1:0]          pool_im;
    logic [W-1:0]                    pool_om;
    logic                            out_valid;
    logic                            out_ready = 1'b1;
    logic [W-1:0]                    out_data;
    logic [IDW-1:0]                  out_id;
    logic                            err;
    logic [IDW-1:0]                  err_id;

    pool_scheduler #(.IL(8), .FL(12), .size(SIZE), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .win(win), .ack(ack),
        .pool_en(pool_en), .pool_load(pool_load), .pool_im(pool_im),
        .pool_om(pool_om), .pool_done(pool_done), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
        .err(err), .err_id(err_id)
    );

    always #5 clk = ~clk;

    // Behavioural pooling unit: done SIZE cycles after load, result = signed mean.
    logic [3:0]          pc;
    logic                pool_hang = 1'b0;
    logic signed [W+1:0] msum;
    always_comb begin
        msum = '0;
        for (int k = 0; k < SIZE; k++) begin
            msum = msum + $signed({{2{pool_im[k][W-1]}}, pool_im[k]});
        end
    end
    assign pool_done = !pool_hang && (pc == 4'(SIZE));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= 4'd0;
            pool_om <= '0;
        end else if (pool_en && pool_load) begin
            pc <= 4'd1;
        end else if (pool_en && pool_done) begin
            pool_om <= msum[W+1:2];
            pc      <= 4'd0;
        end else if (pool_en && pc != 4'd0 && pc != 4'd15) begin
            pc <= pc + 4'd1;
        end
    end

    typedef struct {
        logic [N-1:0]              rq;
        logic [SIZE-1:0][W-1:0]    w;
        int                        eid;
        logic [W-1:0]              mean;
        int                        drop;
    } vec_t;

    vec_t vecs[6];
    int   pass_cnt = 0;
    int   tot_cnt  = 0;

    task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic vec_t mkvec(input logic [N-1:0] rq, input logic [W-1:0] w0, input logic [W-1:0] w1,
                                   input logic [W-1:0] w2, input logic [W-1:0] w3, input int eid,
                                   input logic [W-1:0] mean, input int drop);
        vec_t v;
        v.rq = rq; v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.eid = eid; v.mean = mean; v.drop = drop;
        return v;
    endfunction

    task automatic set_win(input int eid, input logic [SIZE-1:0][W-1:0] w);
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < SIZE; k++) begin
                win[i][k] = (i == eid) ? w[k] : 20'hFFFFF;
            end
        end
    endtask

    task automatic run_job(input vec_t v, input string nm);
        int lat;
        logic [N-1:0] ack_seen;
        lat = 0;
        ack_seen = '0;
        set_win(v.eid, v.w);
        req = v.rq;
        for (int c = 1; c <= 30 && lat == 0; c++) begin
            @(negedge clk);
            if (v.drop != 0 && c == v.drop) req = '0;
            if (ack != '0) begin
                lat = c;
                ack_seen = ack;
            end
        end
        check(ack_seen == (4'b0001 << v.eid), {nm, "_ack"}, 32'(ack_seen), 32'(4'b0001 << v.eid));
        check(lat == 6, {nm, "_latency"}, 32'(lat), 32'd6);
        req = '0;
        @(negedge clk);
        check(ack == '0, {nm, "_ack_pulse"}, 32'(ack), 32'd0);
        check(out_valid == 1'b1, {nm, "_valid"}, 32'(out_valid), 32'd1);
        check(out_data == v.mean, {nm, "_data"}, 32'(out_data), 32'(v.mean));
        check(out_id == IDW'(v.eid), {nm, "_id"}, 32'(out_id), 32'(v.eid));
        @(negedge clk);
    endtask

    task automatic wait_ack(input int budget, output logic [N-1:0] a);
        a = '0;
        for (int c = 0; c < budget && a == '0; c++) begin
            @(negedge clk);
            a = ack;
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            ok = out_valid;
        end
    endtask

    initial begin
        logic [N-1:0] a;
        logic [SIZE-1:0][W-1:0] wtmp;
        int exp_seq[5];
        bit ok;
        bit seen_valid;
        logic [W-1:0] d0;

        vecs[0] = mkvec(4'b0100, 20'h01000, 20'h02000, 20'h03000, 20'h06000, 2, 20'h03000, 0);
        vecs[1] = mkvec(4'b1111, 20'h00004, 20'h00008, 20'h0000C, 20'h00010, 3, 20'h0000A, 0);
        vecs[2] = mkvec(4'b0110, 20'h10000, 20'h10000, 20'h20000, 20'h20000, 1, 20'h18000, 3);
        vecs[3] = mkvec(4'b0001, 20'hFF000, 20'hFF000, 20'hFF000, 20'hFF000, 0, 20'hFF000, 0);
        vecs[4] = mkvec(4'b1001, 20'h00001, 20'h00002, 20'h00003, 20'h00006, 3, 20'h00003, 0);
        vecs[5] = mkvec(4'b1100, 20'h12345, 20'h12345, 20'h12345, 20'h12345, 2, 20'h12345, 0);
        exp_seq = '{0, 1, 2, 3, 0};

        repeat (3) @(negedge clk);
        check(ack == '0 && pool_en == 1'b0 && pool_load == 1'b0, "reset_ctrl", {ack, pool_en, pool_load}, 32'd0);
        check(out_valid == 1'b0 && out_data == '0 && out_id == '0, "reset_out", 32'(out_data), 32'd0);
        check(err == 1'b0 && err_id == '0, "reset_err", {err, err_id}, 32'd0);

        // All requesters held high from reset: strict round-robin order.
        req = 4'b1111;
        rst_n = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_ack(30, a);
            check(a == (4'b0001 << exp_seq[g]), "rr_order", 32'(a), 32'(4'b0001 << exp_seq[g]));
            @(negedge clk);
            check(ack == '0, "rr_ack_pulse", 32'(ack), 32'd0);
        end
        req = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: hold the result, then grant the next requester after one IDLE cycle.
        out_ready = 1'b0;
        for (int k = 0; k < SIZE; k++) begin
            win[0][k] = 20'h00400;
            win[2][k] = 20'(32'h100 * (k + 1));
            win[1][k] = 20'hFFFFF;
            win[3][k] = 20'hFFFFF;
        end
        req = 4'b0101;
        wait_ack(30, a);
        check(a == 4'b0001, "bp_first_ack", 32'(a), 32'h1);
        req = 4'b0100;
        wait_valid(10, ok);
        check(ok, "bp_valid", 32'(ok), 32'd1);
        d0 = out_data;
        check(d0 == 20'h00400, "bp_data", 32'(d0), 32'h400);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check(out_valid && out_data == 20'h00400 && out_id == 2'd0 && !pool_load, "bp_hold",
                  {out_valid, pool_load, out_data}, {2'b10, 20'h00400});
        end
        out_ready = 1'b1;
        @(negedge clk);
        check(!out_valid && !pool_load, "bp_idle_gap", {out_valid, pool_load}, 32'd0);
        @(negedge clk);
        check(pool_load == 1'b1, "bp_next_load", 32'(pool_load), 32'd1);
        wait_ack(30, a);
        check(a == 4'b0100, "bp_second_ack", 32'(a), 32'h4);
        req = '0;
        wait_valid(10, ok);
        check(ok && out_data == 20'h00280 && out_id == 2'd2, "bp_second_result", 32'(out_data), 32'h280);
        @(negedge clk);

        // Watchdog abort on a hung pooling unit, then a normal job.
        pool_hang = 1'b1;
        req = 4'b1000;
        seen_valid = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
            ok = err;
        end
        check(ok && err_id == 2'd3, "wd_err", {err, err_id}, {1'b1, 2'd3});
        check(ack == 4'b1000, "wd_ack", 32'(ack), 32'h8);
        req = '0;
        @(negedge clk);
        check(err == 1'b0 && err_id == 2'd3, "wd_err_pulse", {err, err_id}, 32'd3);
        repeat (2) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check(!seen_valid, "wd_no_valid", 32'(seen_valid), 32'd0);
        pool_hang = 1'b0;
        run_job(mkvec(4'b0001, 20'h00010, 20'h00020, 20'h00030, 20'h00040, 0, 20'h00028, 0), "after_wd");

        // Asynchronous reset while RUN is in progress.
        for (int k = 0; k < SIZE; k++) wtmp[k] = 20'h00800;
        set_win(1, wtmp);
        req = 4'b0010;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            ok = pool_en && !pool_load;
        end
        check(ok, "rst_reach_run", 32'(ok), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check(ack == '0 && pool_en == 1'b0 && pool_load == 1'b0, "rst_ctrl", {ack, pool_en, pool_load}, 32'd0);
        check(out_valid == 1'b0 && out_data == '0 && out_id == '0, "rst_out", 32'(out_data), 32'd0);
        check(err == 1'b0 && err_id == '0, "rst_err", {err, err_id}, 32'd0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_job(mkvec(4'b0010, 20'h04000, 20'h00000, 20'h00000, 20'h00000, 1, 20'h01000, 0), "after_rst");

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
